// File: rtl/if_prefetch_queue.sv
// ----------------------------------------------------------------------------
// if_prefetch_queue
//
// Instruction-fetch front end for the RV32I 5-stage pipeline. Generates the
// fetch PC, issues in-order requests to instruction memory over a
// req/gnt/rvalid handshake, buffers returned words in a DEPTH-entry queue and
// hands them to decode over a valid/ready handshake. A redirect from EX
// flushes the queue, retargets the PC and discards every response that is
// still in flight.
//
// Optional feature macro: IF_PREDECODE_EN
//   defined   : opcode/rd/funct3/rs1/rs2/funct7 are sliced from instr_o
//   undefined : those ports are present but tied to 0
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   imem_req_o      fetch request valid
//   imem_addr_o     fetch address (word aligned), stable while req & !gnt
//   imem_gnt_i      request accepted when high together with imem_req_o
//   imem_rvalid_i   response valid (responses return in request order)
//   imem_rdata_i    response instruction word
//   redirect_i      flush + redirect from EX
//   redirect_pc_i   redirect target, bits [1:0] forced to 0
//   instr_valid_o   queue head valid to decode
//   instr_ready_i   decode accepts the head
//   instr_o         head instruction, NOP (32'h13) when empty
//   instr_pc_o      PC of the head instruction
//   queue_cnt_o     current queue occupancy
//   opcode_o .. funct7_o  predecoded fields of instr_o
// ----------------------------------------------------------------------------
module if_prefetch_queue #(
    parameter int              XLEN            = 32,
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req_o,
    output logic [XLEN-1:0]        imem_addr_o,
    input  logic                   imem_gnt_i,
    input  logic                   imem_rvalid_i,
    input  logic [31:0]            imem_rdata_i,
    input  logic                   redirect_i,
    input  logic [XLEN-1:0]        redirect_pc_i,
    output logic                   instr_valid_o,
    input  logic                   instr_ready_i,
    output logic [31:0]            instr_o,
    output logic [XLEN-1:0]        instr_pc_o,
    output logic [$clog2(DEPTH):0] queue_cnt_o,
    output logic [6:0]             opcode_o,
    output logic [4:0]             rd_o,
    output logic [2:0]             funct3_o,
    output logic [4:0]             rs1_o,
    output logic [4:0]             rs2_o,
    output logic [6:0]             funct7_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW:0]   DEPTH_C = DEPTH[CW:0];
    localparam logic [CW-1:0] MAXO_C  = MAX_OUTSTANDING[CW-1:0];
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(3);
    endfunction

    // Control state
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;

    // Queue storage (data only, never reset)
    logic [31:0]     q_instr [DEPTH];
    logic [XLEN-1:0] q_pc    [DEPTH];

    logic            grant;
    logic            resp_valid;
    logic            resp_drop;
    logic            push;
    logic            pop;
    logic            head_valid;
    logic [CW:0]     credit;

    // Credits cover both queued words and words still in flight, so every
    // granted request is guaranteed a free slot when it returns.
    assign credit     = {1'b0, outstanding} + {1'b0, count};
    assign imem_req_o = !rst && !redirect_i && (credit < DEPTH_C) && (outstanding < MAXO_C);
    assign imem_addr_o = fetch_pc;
    assign grant      = imem_req_o && imem_gnt_i;

    // A response with nothing outstanding is a protocol violation and is ignored.
    assign resp_valid = !rst && imem_rvalid_i && (outstanding != '0);
    assign resp_drop  = resp_valid && (redirect_i || (drop != '0));
    assign push       = resp_valid && !resp_drop;

    assign head_valid    = (count != '0);
    assign instr_valid_o = head_valid && !redirect_i && !rst;
    assign pop           = instr_valid_o && instr_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            case ({grant, resp_valid})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: ;
            endcase

            if (redirect_i) begin
                fetch_pc <= align_pc(redirect_pc_i);
                resp_pc  <= align_pc(redirect_pc_i);
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                // Everything still in flight after this cycle belongs to the
                // old path. Words already marked for dropping are a subset of
                // the outstanding ones, so the new drop count is simply what
                // remains outstanding; a response arriving now is consumed
                // here, and resp_valid implies outstanding >= 1 (no underflow).
                drop <= resp_valid ? (outstanding - CW'(1)) : outstanding;
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (push) begin
                    resp_pc <= resp_pc + XLEN'(4);
                    wr_ptr  <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (resp_drop) begin
                    drop <= drop - CW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: ;
                endcase
            end
        end
    end

    // Queue write: push is already qualified by reset and redirect.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= imem_rdata_i;
            q_pc[wr_ptr]    <= resp_pc;
        end
    end

    // Output stage: head of the registered queue, no bypass from memory.
    // When empty the PC output shows the next expected response PC.
    assign instr_o     = (head_valid && !rst) ? q_instr[rd_ptr] : NOP;
    assign instr_pc_o  = rst ? RESET_PC : (head_valid ? q_pc[rd_ptr] : resp_pc);
    assign queue_cnt_o = rst ? '0 : count;

`ifdef IF_PREDECODE_EN
    logic [31:0] pd_word;

    assign pd_word  = rst ? 32'h0 : instr_o;
    assign opcode_o = pd_word[6:0];
    assign rd_o     = pd_word[11:7];
    assign funct3_o = pd_word[14:12];
    assign rs1_o    = pd_word[19:15];
    assign rs2_o    = pd_word[24:20];
    assign funct7_o = pd_word[31:25];
`else
    assign opcode_o = '0;
    assign rd_o     = '0;
    assign funct3_o = '0;
    assign rs1_o    = '0;
    assign rs2_o    = '0;
    assign funct7_o = '0;
`endif

`ifndef SYNTHESIS
    a_rvalid_without_request: assert property (
        @(posedge clk) disable iff (rst) !(imem_rvalid_i && (outstanding == '0))
    );
`endif

endmodule
